// File: rtl/dg0045_pkg.sv
// Shared types and constants for the DG0045 machine-cycle sequencer.
package dg0045_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } seq_state_t;

    localparam int unsigned MCYCLE_LEN = 8;

    localparam logic [2:0] PH_F1_LO = 3'd2;
    localparam logic [2:0] PH_F1_HI = 3'd3;
    localparam logic [2:0] PH_F2_LO = 3'd6;
    localparam logic [2:0] PH_F2_HI = 3'd7;
    localparam logic [2:0] PH_LAST  = 3'(MCYCLE_LEN - 1);

    function automatic logic in_window(input logic [2:0] ph, input logic [2:0] lo,
                                       input logic [2:0] hi);
        return (ph >= lo) && (ph <= hi);
    endfunction

endpackage

// File: rtl/dg0045_phase_gen.sv
// Phase counter with registered F1/F2 strobes and machine-cycle boundary flag.
module dg0045_phase_gen
    import dg0045_pkg::*;
(
    input  logic       clk_in,
    input  logic       RESET,
    input  logic       i_cnt_en,
    input  logic       i_strobe_en,
    output logic [2:0] o_phase,
    output logic       o_f1,
    output logic       o_f2,
    output logic       o_bnd
);

    logic [2:0] r_phase;
    logic       r_f1;
    logic       r_f2;
    logic [2:0] w_phase_nxt;

    // Strobes are decoded from the phase being loaded so they leave a flop edge-aligned.
    assign w_phase_nxt = i_cnt_en ? (r_phase + 3'd1) : 3'd0;
    assign o_bnd       = i_cnt_en && (r_phase == PH_LAST);

    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            r_phase <= 3'd0;
            r_f1    <= 1'b0;
            r_f2    <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_f1    <= i_strobe_en && in_window(w_phase_nxt, PH_F1_LO, PH_F1_HI);
            r_f2    <= i_strobe_en && in_window(w_phase_nxt, PH_F2_LO, PH_F2_HI);
        end
    end

    assign o_phase = r_phase;
    assign o_f1    = r_f1;
    assign o_f2    = r_f2;

endmodule

// File: rtl/dg0045_cycle_sequencer.sv
// Run/halt/single-step machine-cycle sequencer for the DG0045 core.
// Optional PC breakpoint is built only when DG0045_BREAKPOINT_EN is defined.
module dg0045_cycle_sequencer
    import dg0045_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CYC_W = 16
) (
    input  logic             clk_in,
    input  logic             RESET,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             F1,
    output logic             F2,
    output logic [2:0]       phase,
    output logic             halted,
    output logic             halt_ack,
    output logic             step_done,
    output logic             bp_hit,
    output logic [CYC_W-1:0] cycle_cnt
);
    // state  | meaning
    // WARMUP | one machine cycle after reset with F1/F2 suppressed
    // RUN    | free-running; halt_req / breakpoint checked at each boundary
    // HALTED | phase held at 0; waiting for run_req or step_req
    // STEP   | exactly one machine cycle, then back to HALTED

    seq_state_t       r_state;
    logic             r_halted;
    logic             r_halt_ack;
    logic             r_step_done;
    logic             r_bp_hit;
    logic [CYC_W-1:0] r_cycle_cnt;

    logic             w_cnt_en;
    logic             w_strobe_en;
    logic             w_bnd;
    logic             w_bp_match;

`ifdef DG0045_BREAKPOINT_EN
    assign w_bp_match = bp_valid && (pc == bp_addr);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{pc, bp_addr, bp_valid};
    assign w_bp_match  = 1'b0;
`endif

    assign w_cnt_en    = (r_state != HALTED);
    assign w_strobe_en = (r_state == RUN) || (r_state == STEP);

    dg0045_phase_gen u_phase_gen (
        .clk_in      (clk_in),
        .RESET       (RESET),
        .i_cnt_en    (w_cnt_en),
        .i_strobe_en (w_strobe_en),
        .o_phase     (phase),
        .o_f1        (F1),
        .o_f2        (F2),
        .o_bnd       (w_bnd)
    );

    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            r_state     <= WARMUP;
            r_halted    <= 1'b0;
            r_halt_ack  <= 1'b0;
            r_step_done <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_halt_ack  <= 1'b0;
            r_step_done <= 1'b0;
            case (r_state)
                WARMUP: begin
                    if (w_bnd) r_state <= RUN;
                end
                RUN: begin
                    if (w_bnd) begin
                        r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
                        if (halt_req) begin
                            r_state    <= HALTED;
                            r_halted   <= 1'b1;
                            r_halt_ack <= 1'b1;
                        end else if (w_bp_match) begin
                            r_state    <= HALTED;
                            r_halted   <= 1'b1;
                            r_halt_ack <= 1'b1;
                            r_bp_hit   <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    // halt_req wins over run_req while both levels are high
                    if (halt_req) begin
                        r_state <= HALTED;
                    end else if (run_req) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                        r_bp_hit <= 1'b0;
                    end else if (step_req) begin
                        r_state  <= STEP;
                        r_halted <= 1'b0;
                    end
                end
                STEP: begin
                    if (w_bnd) begin
                        r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
                        r_state     <= HALTED;
                        r_halted    <= 1'b1;
                        r_step_done <= 1'b1;
                    end
                end
                default: r_state <= WARMUP;
            endcase
        end
    end

    assign halted    = r_halted;
    assign halt_ack  = r_halt_ack;
    assign step_done = r_step_done;
    assign bp_hit    = r_bp_hit;
    assign cycle_cnt = r_cycle_cnt;

endmodule
